fifo_sched: RTL and testbench
=============================

FIFO_SCHED -- requirements
Module: fifo_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of write requesters.
REQ-002 The block SHALL have parameter WIDTH, default 4, meaning the data width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 5, meaning the capacity of the attached FIFO in words.
REQ-004 The block SHALL use one clock, clk, and a reset, rst, that is asynchronous and active-low.
REQ-005 Port clk: input, 1 bit, rising-edge clock.
REQ-006 Port rst: input, 1 bit, asynchronous active-low reset.
REQ-007 Port req: input, NREQ bits, per-requester write request, held high until granted.
REQ-008 Port wdata_in: input, NREQ*WIDTH bits, packed write data; requester i uses bits [i*WIDTH +: WIDTH].
REQ-009 Port gnt: output, NREQ bits, one-hot write grant, high in the cycle the requester's word is written.
REQ-010 Port rd_req: input, 1 bit, consumer level request for reads.
REQ-011 Port rd_valid: output, 1 bit, rd_data holds a valid word this cycle.
REQ-012 Port rd_data: output, WIDTH bits, read word, driven combinationally from fifo_rdata.
REQ-013 Port fifo_wr / fifo_rd: output, 1 bit each, FIFO write and read strobes.
REQ-014 Port fifo_wdata: output, WIDTH bits, FIFO write data.
REQ-015 Port fifo_rdata: input, WIDTH bits, FIFO registered read data.
REQ-016 Port fifo_full / fifo_empty: input, 1 bit each, FIFO status flags.
REQ-017 Port count: output, $clog2(DEPTH+1) bits, number of words issued into the FIFO and not yet read.
REQ-018 Port err: output, 1 bit, sticky protocol error.

Function
REQ-019 The block SHALL make a decision at each rising edge; the selected operation appears on registered outputs for exactly one cycle, the cycle after that edge.
REQ-020 Write eligibility: (|req) and count < DEPTH. Read eligibility: rd_req and count > 0.
REQ-021 The block SHALL never assert fifo_wr and fifo_rd in the same cycle, because the FIFO ignores simultaneous rd/wr.
REQ-022 When both operations are eligible, the block SHALL issue the opposite of last_op, the last issued operation; otherwise it SHALL issue the single eligible operation, or none.
REQ-023 Write arbitration SHALL be round-robin: ptr marks the highest-priority requester; grant the first req[i] set, searching cyclically from ptr; then ptr <= (i+1) mod NREQ.
REQ-024 On a write decision, gnt[i], fifo_wr and fifo_wdata = wdata_in[i] (captured at the decision edge) SHALL be asserted together in the next cycle.
REQ-025 A req bit still high during its gnt cycle SHALL count as a new request, allowing back-to-back words.
REQ-026 On a read decision, fifo_rd SHALL be high in the next cycle, and rd_valid SHALL be high one cycle later with rd_data = fifo_rdata.
REQ-027 count SHALL update at the decision edge: +1 on a write decision, -1 on a read decision, held otherwise; it SHALL stay within 0..DEPTH.
REQ-028 err SHALL be set, and remain set until reset, if fifo_wr=1 while fifo_full=1, or fifo_rd=1 while fifo_empty=1.
REQ-029 With count=DEPTH, requests SHALL be held off with no grant; with count=0, rd_req SHALL be ignored.

Reset
REQ-030 While rst=0, the block SHALL immediately force the following to 0: gnt, fifo_wr, fifo_rd, fifo_wdata, rd_valid, count, err, and ptr.
REQ-031 While rst=0, last_op SHALL be set to read, so that the first contended decision issues a write.
REQ-032 Reset asserted mid-operation SHALL cancel any pending strobe or rd_valid; no grant or read SHALL be issued while rst=0.
REQ-033 Normal decisions SHALL begin at the first rising edge after rst returns to 1.

Verification
REQ-034 Directed test: hold req=4'b1111 with distinct data and rd_req=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001; count reaches 5; no further grants.
REQ-035 Directed test: at count=5 assert rd_req=1 with req=4'b1111 held -> strobes alternate rd, wr, rd, wr; fifo_rd and fifo_wr are never high together; count oscillates between 4 and 5.
REQ-036 Directed test: write 3, A, 5 from requester 0, then rd_req=1 -> rd_valid pulses carry 3, A, 5, each 2 cycles after its decision edge; count ends at 0.
REQ-037 Directed test: force fifo_full=1 while a write is issued -> err=1 and remains 1 until rst=0.
REQ-038 Directed test: drive rst=0 mid-stream during a fifo_wr cycle -> all outputs are 0 immediately; after release the first grant goes to requester 0.
REQ-039 Directed test: count=0 with rd_req=1 -> no fifo_rd and no rd_valid for 10 cycles.

Source files
------------

// File: rtl/fifo_sched.sv
// Write/read scheduler in front of a single-port-strobe FIFO: round-robin write
// arbitration across NREQ requesters, alternating with reads when both contend.
module fifo_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*WIDTH-1:0]        wdata_in,
  output logic [NREQ-1:0]              gnt,
  input  logic                         rd_req,
  output logic                         rd_valid,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         fifo_wr,
  output logic                         fifo_rd,
  output logic [WIDTH-1:0]             fifo_wdata,
  input  logic [WIDTH-1:0]             fifo_rdata,
  input  logic                         fifo_full,
  input  logic                         fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  op_t              last_op, last_op_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [PW-1:0]    sel;
  logic             found;
  logic [CW-1:0]    count_nxt;
  logic [NREQ-1:0]  gnt_nxt;
  logic [WIDTH-1:0] wdata_nxt;
  logic             wr_nxt, rd_nxt, rd_valid_nxt, err_nxt;
  logic             wr_elig, rd_elig, do_wr, do_rd;
  int unsigned      idx, base;

  // Read data comes straight from the FIFO's registered output.
  assign rd_data = fifo_rdata;

  // Decision logic: eligibility, round-robin pick, and read/write alternation.
  always_comb begin
    last_op_nxt  = last_op;
    ptr_nxt      = ptr;
    count_nxt    = count;
    gnt_nxt      = '0;
    wdata_nxt    = '0;
    wr_nxt       = 1'b0;
    rd_nxt       = 1'b0;
    sel          = '0;
    found        = 1'b0;
    idx          = 0;
    base         = 0;
    rd_valid_nxt = fifo_rd;
    err_nxt      = err | (fifo_wr & fifo_full) | (fifo_rd & fifo_empty);

    wr_elig = (|req) && (count < CW'(DEPTH));
    rd_elig = rd_req && (count != '0);

    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end

    // Under contention the previous operation loses; reset leaves OP_RD so writes go first.
    do_wr = wr_elig && (!rd_elig || (last_op == OP_RD));
    do_rd = rd_elig && !do_wr;

    if (do_wr) begin
      base        = 32'(sel) * WIDTH;
      gnt_nxt     = NREQ'(1) << sel;
      wr_nxt      = 1'b1;
      wdata_nxt   = wdata_in[base +: WIDTH];
      ptr_nxt     = ((32'(sel) + 1) >= NREQ) ? '0 : sel + PW'(1);
      count_nxt   = count + CW'(1);
      last_op_nxt = OP_WR;
    end else if (do_rd) begin
      rd_nxt      = 1'b1;
      count_nxt   = count - CW'(1);
      last_op_nxt = OP_RD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_op    <= OP_RD;
      ptr        <= '0;
      count      <= '0;
      gnt        <= '0;
      fifo_wr    <= 1'b0;
      fifo_rd    <= 1'b0;
      fifo_wdata <= '0;
      rd_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      last_op    <= last_op_nxt;
      ptr        <= ptr_nxt;
      count      <= count_nxt;
      gnt        <= gnt_nxt;
      fifo_wr    <= wr_nxt;
      fifo_rd    <= rd_nxt;
      fifo_wdata <= wdata_nxt;
      rd_valid   <= rd_valid_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_sched.sv
// Directed bench for fifo_sched with a small behavioural FIFO attached.
module tb_fifo_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   wdata_in;
  logic [NREQ-1:0]         gnt;
  logic                    rd_req;
  logic                    rd_valid;
  logic [WIDTH-1:0]        rd_data;
  logic                    fifo_wr;
  logic                    fifo_rd;
  logic [WIDTH-1:0]        fifo_wdata;
  logic [WIDTH-1:0]        fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           count;
  logic                    err;
  logic                    force_full;

  int errors = 0;
  int checks = 0;

  fifo_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wdata_in   (wdata_in),
    .gnt        (gnt),
    .rd_req     (rd_req),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fifo_wr    (fifo_wr),
    .fifo_rd    (fifo_rd),
    .fifo_wdata (fifo_wdata),
    .fifo_rdata (fifo_rdata),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .count      (count),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO with registered read data.
  logic [WIDTH-1:0] mem[$];
  int qn;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem.delete();
      qn         <= 0;
      fifo_rdata <= '0;
    end else begin
      if (fifo_wr) begin
        mem.push_back(fifo_wdata);
        qn <= qn + 1;
      end else if (fifo_rd && (mem.size() > 0)) begin
        fifo_rdata <= mem.pop_front();
        qn <= qn - 1;
      end
    end
  end

  assign fifo_full  = force_full || (qn == int'(DEPTH));
  assign fifo_empty = (qn == 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] wr_dat [4];
    wr_dat[0] = 4'hA; wr_dat[1] = 4'hB; wr_dat[2] = 4'hC; wr_dat[3] = 4'hD;

    rst = 1'b0; req = '0; rd_req = 1'b0; wdata_in = '0; force_full = 1'b0;
    step(); step();
    chk("rst_gnt",      32'(gnt),      32'h0);
    chk("rst_fifo_wr",  32'(fifo_wr),  32'h0);
    chk("rst_fifo_rd",  32'(fifo_rd),  32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_count",    32'(count),    32'h0);
    chk("rst_err",      32'(err),      32'h0);

    // Fill: all four requesters held, no reads.
    rst = 1'b1; req = 4'b1111; wdata_in = 16'hDCBA;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("fill_gnt%0d", k),   32'(gnt),        32'(4'b0001 << (k % 4)));
      chk($sformatf("fill_wr%0d", k),    32'(fifo_wr),    32'h1);
      chk($sformatf("fill_wdata%0d", k), 32'(fifo_wdata), 32'(wr_dat[k % 4]));
      chk($sformatf("fill_count%0d", k), 32'(count),      32'(k + 1));
    end
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("full_gnt%0d", k),   32'(gnt),     32'h0);
      chk($sformatf("full_wr%0d", k),    32'(fifo_wr), 32'h0);
      chk($sformatf("full_count%0d", k), 32'(count),   32'h5);
    end

    // Contention at full: read, write, read, write ...; writes continue from requester 1.
    rd_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("alt_rd%0d", k),    32'(fifo_rd),            32'((k % 2) == 0));
      chk($sformatf("alt_wr%0d", k),    32'(fifo_wr),            32'((k % 2) == 1));
      chk($sformatf("alt_excl%0d", k),  32'(fifo_rd && fifo_wr), 32'h0);
      chk($sformatf("alt_count%0d", k), 32'(count),              ((k % 2) == 0) ? 32'h4 : 32'h5);
      if ((k % 2) == 1) chk($sformatf("alt_gnt%0d", k), 32'(gnt), 32'(4'b0001 << ((k + 1) / 2)));
    end
    chk("alt_err", 32'(err), 32'h0);

    // Write 3, A, 5 from requester 0, then drain.
    rst = 1'b0; req = '0; rd_req = 1'b0;
    step();
    rst = 1'b1; req = 4'b0001; wdata_in = 16'h0003;
    step();
    chk("wr3_gnt",   32'(gnt),        32'h1);
    chk("wr3_wdata", 32'(fifo_wdata), 32'h3);
    wdata_in = 16'h000A;
    step();
    chk("wrA_gnt",   32'(gnt),        32'h1);
    chk("wrA_wdata", 32'(fifo_wdata), 32'hA);
    wdata_in = 16'h0005;
    step();
    chk("wr5_wdata", 32'(fifo_wdata), 32'h5);
    chk("wr5_count", 32'(count),      32'h3);
    req = '0; rd_req = 1'b1;
    step();
    chk("rd0_strobe", 32'(fifo_rd),  32'h1);
    chk("rd0_valid",  32'(rd_valid), 32'h0);
    chk("rd0_count",  32'(count),    32'h2);
    step();
    chk("rd1_valid", 32'(rd_valid), 32'h1);
    chk("rd1_data",  32'(rd_data),  32'h3);
    step();
    chk("rd2_valid", 32'(rd_valid), 32'h1);
    chk("rd2_data",  32'(rd_data),  32'hA);
    chk("rd2_count", 32'(count),    32'h0);
    step();
    chk("rd3_strobe", 32'(fifo_rd),  32'h0);
    chk("rd3_valid",  32'(rd_valid), 32'h1);
    chk("rd3_data",   32'(rd_data),  32'h5);
    chk("rd3_err",    32'(err),      32'h0);

    // Empty with rd_req held: nothing happens.
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("empty_idle%0d", k), 32'({fifo_rd, rd_valid}), 32'h0);
    end

    // Write issued while FIFO reports full sets a sticky error.
    rd_req = 1'b0; req = 4'b0001; wdata_in = 16'h0007; force_full = 1'b1;
    step();
    chk("ovf_wr",  32'(fifo_wr), 32'h1);
    chk("ovf_err0", 32'(err),    32'h0);
    req = '0;
    step();
    chk("ovf_err1", 32'(err), 32'h1);
    force_full = 1'b0;
    step(); step(); step();
    chk("ovf_sticky", 32'(err), 32'h1);

    // Reset in the middle of a write cycle.
    req = 4'b1111; wdata_in = 16'hDCBA;
    step();
    chk("mid_gnt1", 32'(gnt), 32'h2);
    step();
    chk("mid_gnt2",  32'(gnt),     32'h4);
    chk("mid_wr",    32'(fifo_wr), 32'h1);
    chk("mid_count", 32'(count),   32'h3);
    rst = 1'b0;
    #1;
    chk("mrst_gnt",   32'(gnt),        32'h0);
    chk("mrst_wr",    32'(fifo_wr),    32'h0);
    chk("mrst_rd",    32'(fifo_rd),    32'h0);
    chk("mrst_wdata", 32'(fifo_wdata), 32'h0);
    chk("mrst_valid", 32'(rd_valid),   32'h0);
    chk("mrst_count", 32'(count),      32'h0);
    chk("mrst_err",   32'(err),        32'h0);
    step();
    chk("mrst_hold_gnt", 32'(gnt), 32'h0);
    rst = 1'b1;
    step();
    chk("post_gnt",   32'(gnt),        32'h1);
    chk("post_wdata", 32'(fifo_wdata), 32'hA);
    chk("post_count", 32'(count),      32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
